// File: rtl/mvm_pkg.sv
// Shared definitions for the matrix-vector multiplier output stage.
// Default widths and depths, the saturation bounds for the default output
// width, and the FIFO entry layout {last, sat, data}.
package mvm_pkg;

  localparam int MVM_IN_WIDTH  = 24;
  localparam int MVM_OUT_WIDTH = 16;
  localparam int MVM_DEPTH     = 8;
  localparam int MVM_VEC_LEN   = 4;

  localparam logic signed [MVM_OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(MVM_OUT_WIDTH-1){1'b1}}};
  localparam logic signed [MVM_OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(MVM_OUT_WIDTH-1){1'b0}}};

  typedef struct packed {
    logic                             last;
    logic                             sat;
    logic signed [MVM_OUT_WIDTH-1:0]  data;
  } fifo_entry_t;

endpackage

// File: rtl/mvm_out_sat_fifo_sat_clip.sv
// sat_clip: combinational IN_WIDTH -> OUT_WIDTH signed clipper with a flag
// that reports when the value had to be clipped.
// Optional build macro MVM_OUT_RELU_EN: negative inputs are forced to 0
// (not flagged) before the positive-overflow clip.
module sat_clip
  import mvm_pkg::*;
#(
  parameter int IN_WIDTH  = MVM_IN_WIDTH,
  parameter int OUT_WIDTH = MVM_OUT_WIDTH
) (
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_sat
);

  // Largest representable output value, expressed at input width so the
  // comparison is done without truncating the input.
  localparam logic signed [IN_WIDTH-1:0]  HI_IN  = IN_WIDTH'((64'sd1 <<< (OUT_WIDTH-1)) - 64'sd1);
  localparam logic signed [OUT_WIDTH-1:0] HI_OUT = {1'b0, {(OUT_WIDTH-1){1'b1}}};
`ifndef MVM_OUT_RELU_EN
  localparam logic signed [IN_WIDTH-1:0]  LO_IN  = ~HI_IN;
  localparam logic signed [OUT_WIDTH-1:0] LO_OUT = ~HI_OUT;
`endif

  // Returns {sat, data}. When OUT_WIDTH == IN_WIDTH neither bound can be
  // crossed, so sat is always 0.
  function automatic logic [OUT_WIDTH:0] clip(input logic signed [IN_WIDTH-1:0] x);
    logic [OUT_WIDTH:0] r;
`ifdef MVM_OUT_RELU_EN
    if (x[IN_WIDTH-1])
      r = '0;
    else if (x > HI_IN)
      r = {1'b1, HI_OUT};
    else
      r = {1'b0, x[OUT_WIDTH-1:0]};
`else
    if (x > HI_IN)
      r = {1'b1, HI_OUT};
    else if (x < LO_IN)
      r = {1'b1, LO_OUT};
    else
      r = {1'b0, x[OUT_WIDTH-1:0]};
`endif
    return r;
  endfunction

  assign {out_sat, out_data} = clip(in_data);

endmodule

// File: rtl/mvm_out_sat_fifo.sv
// mvm_out_sat_fifo: output stage of the 4x4 matrix-vector multiplier.
// Saturates each accepted result, tags it with sat/last flags and buffers it
// in a DEPTH-entry FIFO so the multiplier stalls only when the FIFO is full.
// in_ready is derived from registered state only (no full-FIFO pass-through)
// and out_valid from count only (no empty-FIFO bypass).
// Optional build macro MVM_OUT_RELU_EN (handled inside sat_clip).
module mvm_out_sat_fifo
  import mvm_pkg::*;
#(
  parameter int IN_WIDTH  = MVM_IN_WIDTH,
  parameter int OUT_WIDTH = MVM_OUT_WIDTH,
  parameter int DEPTH     = MVM_DEPTH,
  parameter int VEC_LEN   = MVM_VEC_LEN
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [IN_WIDTH-1:0]  in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_sat,
  output logic                        out_last
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

  // Same layout as mvm_pkg::fifo_entry_t, sized by this instance's OUT_WIDTH.
  typedef struct packed {
    logic                         last;
    logic                         sat;
    logic signed [OUT_WIDTH-1:0]  data;
  } entry_t;

  entry_t                      mem [DEPTH];
  logic [PTR_W-1:0]            wr_ptr;
  logic [PTR_W-1:0]            rd_ptr;
  logic [CNT_W-1:0]            count;
  logic [IDX_W-1:0]            elem_idx;
  logic signed [OUT_WIDTH-1:0] clip_data;
  logic                        clip_sat;
  logic                        push;
  logic                        pop;

  sat_clip #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_sat_clip (
    .in_data  (in_data),
    .out_data (clip_data),
    .out_sat  (clip_sat)
  );

  assign in_ready  = !reset && (count < FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_data  = mem[rd_ptr].data;
  assign out_sat   = mem[rd_ptr].sat;
  assign out_last  = mem[rd_ptr].last;

  // Control state: pointers, occupancy and position within the current vector.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      elem_idx <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        elem_idx <= (elem_idx == LAST_IDX) ? '0 : elem_idx + IDX_W'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage: the clipped value and its tags are captured at push time.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{last: (elem_idx == LAST_IDX), sat: clip_sat, data: clip_data};
  end

endmodule

// File: tb/tb_mvm_out_sat_fifo.sv
// Directed bench for mvm_out_sat_fifo (default parameters). Inputs change 1
// time unit after the rising edge; outputs are sampled a further unit later.
// Expected values for the MVM_OUT_RELU_EN build are selected with the macro.
module tb_mvm_out_sat_fifo;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [23:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               out_sat;
  logic               out_last;

  int errors = 0;
  int checks = 0;

  mvm_out_sat_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Occupancy must never exceed DEPTH.
  always @(negedge clk) begin
    if (!reset && int'(dut.count) > 8) begin
      errors++;
      $display("FAIL count_bound: count=%0d limit=8", dut.count);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    reset     = 1'b1;
    tick();
    tick();
    reset     = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 24'(77);
    out_ready = 1'b0;
    tick();
    tick();
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_basic();
    int vals [4] = '{100, -5, 32767, -32768};
`ifdef MVM_OUT_RELU_EN
    int exp_d [4] = '{100, 0, 32767, 0};
`else
    int exp_d [4] = '{100, -5, 32767, -32768};
`endif
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'b1;
      in_data   = 24'(vals[i]);
      out_ready = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_no_bypass[%0d]: got %b expected 0", i, out_valid); end
      tick();
      in_valid = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++;
      if (out_data !== 16'(exp_d[i])) begin errors++; $display("FAIL basic_data[%0d]: got %0d expected %0d", i, out_data, exp_d[i]); end
      checks++;
      if (out_sat !== 1'b0) begin errors++; $display("FAIL basic_sat[%0d]: got %b expected 0", i, out_sat); end
      checks++;
      if (out_last !== (i == 3)) begin errors++; $display("FAIL basic_last[%0d]: got %b expected %b", i, out_last, (i == 3)); end
      tick();
    end
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_saturation();
    int vals [4] = '{40000, -40000, 32768, -32769};
`ifdef MVM_OUT_RELU_EN
    int   exp_d [4] = '{32767, 0, 32767, 0};
    logic exp_s [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    int   exp_d [4] = '{32767, -32768, 32767, -32768};
    logic exp_s [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 24'(vals[i]);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL sat_valid[%0d]: got %b expected 1", i, out_valid); end
      checks++;
      if (out_data !== 16'(exp_d[i])) begin errors++; $display("FAIL sat_data[%0d]: got %0d expected %0d", i, out_data, exp_d[i]); end
      checks++;
      if (out_sat !== exp_s[i]) begin errors++; $display("FAIL sat_flag[%0d]: got %b expected %b", i, out_sat, exp_s[i]); end
      checks++;
      if (out_last !== (i == 3)) begin errors++; $display("FAIL sat_last[%0d]: got %b expected %b", i, out_last, (i == 3)); end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int   p;
    int   q;
    logic pushed;
    logic popped;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 24'(1000 + i);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_fill[%0d]: got %b expected 1", i, in_ready); end
      tick();
    end
    for (int s = 0; s < 3; s++) begin
      in_valid = 1'b1;
      in_data  = 24'(1008);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full[%0d]: got %b expected 0", s, in_ready); end
      checks++;
      if (out_data !== 16'(1000)) begin errors++; $display("FAIL bp_head_hold[%0d]: got %0d expected 1000", s, out_data); end
      tick();
    end
    p = 8;
    q = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && q < 10; cyc++) begin
      in_valid = (p < 10);
      in_data  = 24'(1000 + p);
      #1;
      pushed = in_valid && in_ready;
      popped = out_valid;
      if (out_valid) begin
        checks++;
        if (out_data !== 16'(1000 + q)) begin errors++; $display("FAIL bp_data[%0d]: got %0d expected %0d", q, out_data, 1000 + q); end
        checks++;
        if (out_last !== ((q % 4) == 3)) begin errors++; $display("FAIL bp_last[%0d]: got %b expected %b", q, out_last, ((q % 4) == 3)); end
      end
      tick();
      if (pushed) p++;
      if (popped) q++;
    end
    in_valid = 1'b0;
    checks++;
    if (q != 10 || p != 10) begin errors++; $display("FAIL bp_timeout: popped %0d pushed %0d expected 10 and 10", q, p); end
    out_ready = 1'b0;
  endtask

  task automatic test_full_no_passthrough();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = 24'(2000 + i);
      tick();
    end
    in_valid  = 1'b1;
    in_data   = 24'(2008);
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL full_refuse: in_ready got %b expected 0", in_ready); end
    checks++;
    if (out_data !== 16'(2000)) begin errors++; $display("FAIL full_head: got %0d expected 2000", out_data); end
    tick();
    out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop: in_ready got %b expected 1", in_ready); end
    checks++;
    if (out_data !== 16'(2001)) begin errors++; $display("FAIL full_head2: got %0d expected 2001", out_data); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL full_refilled: in_ready got %b expected 0", in_ready); end
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'(2000 + i)) begin
        errors++; $display("FAIL full_drain[%0d]: got valid=%b data=%0d expected valid=1 data=%0d", i, out_valid, out_data, 2000 + i);
      end
      checks++;
      if (out_last !== ((i % 4) == 3)) begin errors++; $display("FAIL full_last[%0d]: got %b expected %b", i, out_last, ((i % 4) == 3)); end
      tick();
    end
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL full_empty: got %b expected 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int p;
    int q;
    apply_reset();
    p = 0;
    q = 0;
    out_ready = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      in_valid = (p < 20);
      in_data  = 24'(3000 + p);
      #1;
      if (p < 20) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", c, in_ready); end
      end
      if (c > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'(3000 + q)) begin
          errors++; $display("FAIL b2b_data[%0d]: got valid=%b data=%0d expected valid=1 data=%0d", q, out_valid, out_data, 3000 + q);
        end
        checks++;
        if (out_last !== ((q % 4) == 3)) begin errors++; $display("FAIL b2b_last[%0d]: got %b expected %b", q, out_last, ((q % 4) == 3)); end
      end
      tick();
      if (p < 20) p++;
      if (c > 0) q++;
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b expected 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 24'(4000 + i);
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_prefill: got %b expected 1", out_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_flushed: got %b expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %b expected 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 24'(5000 + i);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'(5000 + i)) begin
        errors++; $display("FAIL mid_data[%0d]: got valid=%b data=%0d expected valid=1 data=%0d", i, out_valid, out_data, 5000 + i);
      end
      checks++;
      if (out_last !== (i == 3)) begin errors++; $display("FAIL mid_last[%0d]: got %b expected %b", i, out_last, (i == 3)); end
      tick();
    end
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_empty: got %b expected 0", out_valid); end
    out_ready = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_full_no_passthrough();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
